// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, selectable FWFT read mode and sticky overflow/underflow flags.
module sync_fifo_ctl #(
    parameter int DSIZE      = 8,
    parameter int ASIZE      = 4,
    parameter int AFULL_LVL  = 14,
    parameter int AEMPTY_LVL = 2,
    parameter int FWFT       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 2 ** ASIZE;
    localparam logic [ASIZE:0] DEPTH_C  = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_C  = (ASIZE + 1)'(AFULL_LVL);
    localparam logic [ASIZE:0] AEMPTY_C = (ASIZE + 1)'(AEMPTY_LVL);

    // Reject configurations whose thresholds or depth make no sense.
    if (ASIZE < 1 || AEMPTY_LVL < 0 || AEMPTY_LVL >= AFULL_LVL ||
        AFULL_LVL > DEPTH || (FWFT != 0 && FWFT != 1)) begin : g_bad_cfg
        $error("sync_fifo_ctl: illegal parameter configuration");
    end

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic [ASIZE:0]   count_q;
    logic [ASIZE:0]   next_count;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE-1:0] raddr;
    logic             do_write;
    logic             do_read;

    // Acceptance uses the registered flags, so a full FIFO drops the write and an
    // empty FIFO drops the read when both are requested together.
    assign do_write = winc && !wfull;
    assign do_read  = rinc && !rempty;
    assign waddr    = wptr[ASIZE-1:0];
    assign raddr    = rptr[ASIZE-1:0];
    assign count    = count_q;

    // Occupancy after this edge; all status flags are derived from it.
    always_comb begin
        next_count = count_q;
        case ({do_write, do_read})
            2'b10:   next_count = count_q + 1'b1;
            2'b01:   next_count = count_q - 1'b1;
            default: next_count = count_q;
        endcase
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            count_q       <= '0;
            wfull         <= 1'b0;
            rempty        <= 1'b1;
            walmost_full  <= (AFULL_LVL == 0);
            ralmost_empty <= 1'b1;
        end else begin
            if (do_write) begin
                wptr <= wptr + 1'b1;
            end
            if (do_read) begin
                rptr <= rptr + 1'b1;
            end
            count_q       <= next_count;
            wfull         <= (next_count == DEPTH_C);
            rempty        <= (next_count == '0);
            walmost_full  <= (next_count >= AFULL_C);
            ralmost_empty <= (next_count <= AEMPTY_C);
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[waddr] <= wdata;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rinc && rempty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    if (FWFT == 1) begin : g_fwft
        // Head word falls straight through from the storage array.
        always_comb begin
            rdata = mem[raddr];
        end
    end else begin : g_std
        // Registered read port, updated only when a pop is accepted.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata <= '0;
            end else if (do_read) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: doc/sync_fifo_ctl.md
# sync_fifo_ctl

Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. It is the same-clock-domain counterpart of the team's dual-clock FIFO. It buffers datapath streams between producer/consumer stages that share `clk`, where pointer synchronisers are unnecessary and fill-level visibility is required.

## Interface
- `DSIZE`, 8: data word width in bits.
- `ASIZE`, 4: address width; depth = 2**ASIZE words.
- `AFULL_LVL`, 14: `walmost_full` asserts when count >= this value.
- `AEMPTY_LVL`, 2: `ralmost_empty` asserts when count <= this value.
- `FWFT`, 0: 0 = standard registered read; 1 = first-word-fall-through.
- Legal configurations: ASIZE >= 1; 0 <= AEMPTY_LVL < AFULL_LVL <= 2**ASIZE. Illegal values are an elaboration error.

- `clk`  input  1  single clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `wdata`  input  DSIZE  write data.
- `winc`  input  1  write request.
- `wfull`  output  1  FIFO holds 2**ASIZE words.
- `walmost_full`  output  1  count >= AFULL_LVL.
- `rinc`  input  1  read request (pop).
- `rdata`  output  DSIZE  read data.
- `rempty`  output  1  FIFO holds 0 words.
- `ralmost_empty`  output  1  count <= AEMPTY_LVL.
- `count`  output  ASIZE+1  current occupancy, 0..2**ASIZE.
- `err_clr`  input  1  clears `overflow`/`underflow`.
- `overflow`  output  1  sticky: write attempted while full.
- `underflow`  output  1  sticky: read attempted while empty.

## Operation
- Storage is 2**ASIZE x DSIZE register array. Memory contents are not reset.
- Write and read pointers are ASIZE+1 bits and wrap naturally mod 2**(ASIZE+1). The address is the low ASIZE bits.
- A write is accepted when `winc && !wfull`. On acceptance, `mem[waddr] <= wdata` and `wptr` increments.
- A read is accepted when `rinc && !rempty`. On acceptance, `rptr` increments.
- Flags are sampled pre-edge.
  - Simultaneous write and read while full: the read is accepted and the write is rejected.
  - Simultaneous write and read while empty: the write is accepted and the read is rejected.
- `count` update rules:
  - +1 on write-only acceptance.
  - -1 on read-only acceptance.
  - Unchanged when both are accepted or neither is.
- `wfull`, `rempty`, `walmost_full` and `ralmost_empty` are registered. They are computed from next-count, so they change on the same edge as `count`.
- `overflow` sets on `winc && wfull`. `underflow` sets on `rinc && rempty`.
  - Both flags hold until `err_clr` or `rst`.
  - If a set condition and `err_clr` occur in the same cycle, set wins.
- FWFT=0: `rdata` is a register loaded with `mem[raddr]` on an accepted read. It holds its value otherwise.
- FWFT=1: `rdata = mem[raddr]` combinationally. It is valid whenever `rempty` = 0; `rinc` pops the head word. When `rempty` = 1, `rdata` is don't-care.

## Timing
- Reset values (edge with `rst`=1, priority over all inputs):
  - Pointers = 0 and `count` = 0.
  - `rempty` = 1, `ralmost_empty` = 1.
  - `wfull` = 0, `walmost_full` = (AFULL_LVL==0).
  - `overflow` = `underflow` = 0.
  - `rdata` = 0 when FWFT=0.
- Reset mid-operation discards all contents. Requests asserted during the reset cycle are ignored and do not set error flags.
- Write-to-flag latency: a write accepted at edge N gives `rempty` = 0 and `count` +1 after edge N.
- FWFT=1: `rdata` equals that word after edge N (zero-cycle fall-through from the registered state).
- FWFT=0 read latency: a read accepted at edge N gives the word on `rdata` after edge N. It is stable until the next accepted read.
- Back-to-back: one write and one read per cycle are sustained indefinitely at any non-boundary occupancy.
- Full throughput is also sustained across pointer wrap. Pointer MSBs differ when full and are equal when empty.

## Test plan
- Reset then fill: ASIZE=4, write 0x00..0x0F on consecutive cycles.
  - `count` ramps to 16.
  - `walmost_full` rises after the 14th write.
  - `wfull` rises after the 16th write.
  - A 17th write sets `overflow` and leaves `count` = 16.
- Drain, FWFT=0: 16 consecutive reads return 0x00..0x0F, each one cycle after its `rinc` edge.
  - `ralmost_empty` rises when `count` = 2.
  - `rempty` rises after the 16th read.
  - A further `rinc` sets `underflow`; `rdata` holds 0x0F.
- FWFT=1 single word: write 0xA5 into an empty FIFO.
  - After that edge, `rempty` = 0 and `rdata` = 0xA5 with no `rinc`.
  - A pop returns `rempty` = 1 and `count` = 0.
- Boundary simultaneity:
  - At `count` = 16 with `winc`=`rinc`=1: `count` becomes 15, the head is popped, the write is dropped, and `overflow` = 1.
  - At `count` = 0 with both asserted: `count` becomes 1, and `underflow` = 1.
- Wrap and stream:
  - 100 cycles of simultaneous read/write at `count` = 8 with an incrementing pattern. Data order is preserved across multiple pointer wraps, and `count` stays at 8.
  - Then assert `err_clr` alongside a new overflow: the flag stays set.
- Reset mid-stream: at `count` = 9, assert `rst` together with `winc`/`rinc`. The next cycle shows `count` = 0, `rempty` = 1, and error flags = 0.
